// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the responder FSM state type.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slv_state_e;

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite signal bundle between one master/decoder and one responder.
interface ahb_slave_mem_if;

    logic        Hselx;
    logic [31:0] Haddr;
    logic [1:0]  Htrans;
    logic        Hwrite;
    logic [2:0]  Hsize;
    logic [2:0]  Hburst;
    logic [31:0] Hwdata;
    logic        Hreadyin;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;

    modport slave (
        input  Hselx, Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata, Hreadyin,
        output Hreadyout, Hresp, Hrdata
    );

    modport master (
        output Hselx, Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata, Hreadyin,
        input  Hreadyout, Hresp, Hrdata
    );

endinterface

// File: rtl/ahb_lane_decode.sv
// Maps transfer size and low address bits to little-endian byte strobes
// and flags misaligned halfword/word accesses.
module ahb_lane_decode
    import ahb_pkg::*;
(
    input  logic [2:0] size_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] strb_o,
    output logic       misalign_o
);

    always_comb begin
        strb_o     = 4'b0000;
        misalign_o = 1'b0;
        case (size_i)
            HSIZE_BYTE: strb_o = 4'b0001 << addr_lo_i;
            HSIZE_HALF: begin
                strb_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                misalign_o = addr_lo_i[0];
            end
            HSIZE_WORD: begin
                strb_o     = 4'b1111;
                misalign_o = |addr_lo_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory responder: word-addressed RAM with programmable OKAY wait
// states, byte/halfword/word write lanes and a two-cycle ERROR response.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int unsigned MEM_WORDS   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clock,
    input  logic              Hreset,
    ahb_slave_mem_if.slave    ahb
);

    localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    slv_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             ready_q;
    hresp_e           resp_q;
    logic             write_q;
    logic             err_q;
    logic [IDX_W-1:0] addr_q;
    logic [3:0]       strb_q;

    logic [31:0]      mem [MEM_WORDS];

    logic [31:0]      off;
    logic [3:0]       strb;
    logic             misalign;
    logic             capture;
    logic             accept;
    logic             addr_err;
    logic             commit;
    logic             unused_bits;

    ahb_lane_decode u_lane (
        .size_i     (ahb.Hsize),
        .addr_lo_i  (ahb.Haddr[1:0]),
        .strb_o     (strb),
        .misalign_o (misalign)
    );

    // Offset wraps for addresses below the base, so one compare covers both ends.
    assign off      = ahb.Haddr - ADDR_BASE;
    assign capture  = ahb.Hselx & ahb.Hreadyin & ahb.Htrans[1];
    assign addr_err = (off >= MEM_BYTES) | (ahb.Hsize > HSIZE_WORD) | misalign;
    assign accept   = capture & ((state_q == ST_IDLE) | (state_q == ST_DATA) |
                                 (state_q == ST_ERR2));

    always_comb begin
        state_d = ST_IDLE;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                if (accept) begin
                    if (addr_err) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (Hreset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b1;
            resp_q  <= HRESP_OKAY;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= !((state_d == ST_WAIT) || (state_d == ST_ERR1));
            resp_q  <= ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
            if (accept) begin
                write_q <= ahb.Hwrite;
                err_q   <= addr_err;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            addr_q <= off[IDX_W+1:2];
            strb_q <= strb;
        end
    end

    // A reset on the closing edge drops the write that would otherwise commit.
    assign commit = !Hreset && (state_q == ST_DATA) && write_q && !err_q;

    always_ff @(posedge clock) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (strb_q[b]) begin
                    mem[addr_q][8*b +: 8] <= ahb.Hwdata[8*b +: 8];
                end
            end
        end
    end

    assign ahb.Hreadyout = ready_q;
    assign ahb.Hresp     = resp_q;
    assign ahb.Hrdata    = (((state_q == ST_WAIT) || (state_q == ST_DATA)) && !write_q)
                           ? mem[addr_q] : 32'h0;

    assign unused_bits = ^{off[31:IDX_W+2], off[1:0], ahb.Htrans[0], ahb.Hburst};

endmodule
